// File: rtl/width_upsizer.sv
// -----------------------------------------------------------------------------
// width_upsizer
//   Packs RATIO consecutive WIDTH_DIN-bit input words into one
//   RATIO*WIDTH_DIN-bit output word. A packet ending with din_last may stop
//   mid-group; the partial group is flushed with a lane keep mask and the
//   unfilled lanes read as zero. Valid/ready on both sides, so a stalled sink
//   back-pressures the source. Storage is an accumulator plus one output
//   register; there is no internal FIFO.
//
// Parameters
//   WIDTH_DIN  input word width in bits (>=1)
//   RATIO      input words per output word (2..16)
//   MSB_FIRST  1: first word of a group lands in the top lane; 0: in lane 0
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        asynchronous reset, active-high
//   din_vld    input word valid
//   din_rdy    block accepts input this cycle (combinational from dout_rdy)
//   din_last   final word of a packet (qualified by din_vld & din_rdy)
//   din        input word
//   dout_vld   output word valid
//   dout_rdy   sink accepts output this cycle
//   dout       packed output word
//   dout_keep  bit j=1: lane j (dout[j*WIDTH_DIN +: WIDTH_DIN]) holds data
//   dout_last  output word carries the final word of a packet
// -----------------------------------------------------------------------------
module width_upsizer #(
  parameter int WIDTH_DIN = 8,
  parameter int RATIO     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_vld,
  output logic                       din_rdy,
  input  logic                       din_last,
  input  logic [WIDTH_DIN-1:0]       din,
  output logic                       dout_vld,
  input  logic                       dout_rdy,
  output logic [RATIO*WIDTH_DIN-1:0] dout,
  output logic [RATIO-1:0]           dout_keep,
  output logic                       dout_last
);

  localparam int CW = $clog2(RATIO);
  localparam int DW = RATIO * WIDTH_DIN;
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  logic [CW-1:0]    cnt_reg;
  logic [DW-1:0]    acc_reg;
  logic [DW-1:0]    dout_reg;
  logic [RATIO-1:0] keep_reg;
  logic             last_reg;
  logic             vld_reg;

  logic [CW-1:0]    lane_sel;
  logic [DW-1:0]    acc_next;
  logic [RATIO-1:0] keep_next;
  logic             din_acc;
  logic             group_done;

  // The output register can take a new word whenever it is empty or is
  // being drained in this same cycle.
  assign din_rdy    = ~vld_reg | dout_rdy;
  assign din_acc    = din_vld & din_rdy;
  assign group_done = din_acc & ((cnt_reg == CNT_MAX) | din_last);

  // Lane that the word currently being accepted lands in.
  assign lane_sel = MSB_FIRST ? (CNT_MAX - cnt_reg) : cnt_reg;

  // Per lane: merge the incoming word into the accumulator image, and flag
  // the lane as filled once the group has reached the word that lands there.
  // RANK is the position within the group of the word owning this lane.
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      localparam logic [CW-1:0] LANE = CW'(gi);
      localparam logic [CW-1:0] RANK = MSB_FIRST ? CW'(RATIO - 1 - gi) : CW'(gi);

      assign acc_next[gi*WIDTH_DIN +: WIDTH_DIN] =
        (lane_sel == LANE) ? din : acc_reg[gi*WIDTH_DIN +: WIDTH_DIN];
      assign keep_next[gi] = (RANK <= cnt_reg);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      acc_reg  <= '0;
      dout_reg <= '0;
      keep_reg <= '0;
      last_reg <= 1'b0;
      vld_reg  <= 1'b0;
    end else begin
      if (din_acc) begin
        if (group_done) begin
          // Hand the packed word over and clear the accumulator so the
          // unfilled lanes of a later partial group read as zero.
          dout_reg <= acc_next;
          keep_reg <= keep_next;
          last_reg <= din_last;
          cnt_reg  <= '0;
          acc_reg  <= '0;
        end else begin
          acc_reg  <= acc_next;
          cnt_reg  <= cnt_reg + CW'(1);
        end
      end

      // A completion always (re)loads the output; otherwise an accepted
      // output word empties the register.
      if (group_done) begin
        vld_reg <= 1'b1;
      end else if (dout_rdy) begin
        vld_reg <= 1'b0;
      end
    end
  end

  assign dout_vld  = vld_reg;
  assign dout      = dout_reg;
  assign dout_keep = keep_reg;
  assign dout_last = last_reg;

endmodule

// File: tb/tb_width_upsizer.sv
// -----------------------------------------------------------------------------
// tb_width_upsizer
//   Three instances: idx 0 = W8/R4/MSB_FIRST=1, idx 1 = W8/R4/MSB_FIRST=0,
//   idx 2 = W8/R2/MSB_FIRST=1. Directed steps check the worked examples;
//   a random phase checks every output word against a reference queue that
//   is built from the accepted input words by chunking packets into groups.
// -----------------------------------------------------------------------------
module tb_width_upsizer;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  din_vld;
  logic [2:0]  din_last;
  logic [2:0]  dout_rdy;
  logic [7:0]  din [3];
  bit          rand_rdy;

  wire  [2:0]  din_rdy_w;
  wire  [2:0]  dout_vld_w;
  wire  [2:0]  dout_last_w;
  wire  [31:0] dout_w0;
  wire  [31:0] dout_w1;
  wire  [15:0] dout_w2;
  wire  [3:0]  keep_w0;
  wire  [3:0]  keep_w1;
  wire  [1:0]  keep_w2;

  int          vectors;
  int          miscompares;

  exp_t        expq [3][$];
  logic [7:0]  grp  [3][$];

  width_upsizer #(.WIDTH_DIN(8), .RATIO(4), .MSB_FIRST(1'b1)) u_r4_msb (
    .clk(clk), .rst(rst),
    .din_vld(din_vld[0]), .din_rdy(din_rdy_w[0]), .din_last(din_last[0]), .din(din[0]),
    .dout_vld(dout_vld_w[0]), .dout_rdy(dout_rdy[0]), .dout(dout_w0),
    .dout_keep(keep_w0), .dout_last(dout_last_w[0])
  );

  width_upsizer #(.WIDTH_DIN(8), .RATIO(4), .MSB_FIRST(1'b0)) u_r4_lsb (
    .clk(clk), .rst(rst),
    .din_vld(din_vld[1]), .din_rdy(din_rdy_w[1]), .din_last(din_last[1]), .din(din[1]),
    .dout_vld(dout_vld_w[1]), .dout_rdy(dout_rdy[1]), .dout(dout_w1),
    .dout_keep(keep_w1), .dout_last(dout_last_w[1])
  );

  width_upsizer #(.WIDTH_DIN(8), .RATIO(2), .MSB_FIRST(1'b1)) u_r2_msb (
    .clk(clk), .rst(rst),
    .din_vld(din_vld[2]), .din_rdy(din_rdy_w[2]), .din_last(din_last[2]), .din(din[2]),
    .dout_vld(dout_vld_w[2]), .dout_rdy(dout_rdy[2]), .dout(dout_w2),
    .dout_keep(keep_w2), .dout_last(dout_last_w[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Random sink readiness (70%) while the random phase is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        for (int d = 0; d < 3; d++) dout_rdy[d] = ($urandom_range(0, 99) < 70);
      end
    end
  end

  function automatic int ratio_of(input int d);
    return (d == 2) ? 2 : 4;
  endfunction

  function automatic bit msb_of(input int d);
    return (d != 1);
  endfunction

  function automatic logic [31:0] get_dout(input int d);
    case (d)
      0:       return dout_w0;
      1:       return dout_w1;
      default: return {16'h0, dout_w2};
    endcase
  endfunction

  function automatic logic [3:0] get_keep(input int d);
    case (d)
      0:       return keep_w0;
      1:       return keep_w1;
      default: return {2'b00, keep_w2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input int d, input string tag, input logic [31:0] data,
                         input logic [3:0] keep, input logic last);
    chk($sformatf("%s_vld%0d", tag, d), 32'(dout_vld_w[d]), 32'd1);
    chk($sformatf("%s_dout%0d", tag, d), get_dout(d), data);
    chk($sformatf("%s_keep%0d", tag, d), 32'(get_keep(d)), 32'(keep));
    chk($sformatf("%s_last%0d", tag, d), 32'(dout_last_w[d]), 32'(last));
  endtask

  // Presents one word and returns at posedge+1 after the edge that took it.
  task automatic send_word(input int d, input logic [7:0] w, input logic l, input bit rnd);
    bit took;
    int guard;
    if (rnd) begin
      while ($urandom_range(0, 99) >= 20) begin
        @(posedge clk);
        #1;
      end
    end
    din[d]      = w;
    din_last[d] = l;
    din_vld[d]  = 1'b1;
    took  = 1'b0;
    guard = 0;
    while (!took) begin
      @(negedge clk);
      took = din_rdy_w[d];
      @(posedge clk);
      #1;
      guard++;
      if (!took && guard >= 1000) begin
        miscompares++;
        $display("FAIL send_word%0d: din_rdy low for %0d cycles", d, guard);
        took = 1'b1;
      end
    end
    din_vld[d]  = 1'b0;
    din_last[d] = 1'b0;
  endtask

  task automatic run_random(input int d, input int npk);
    int len;
    for (int p = 0; p < npk; p++) begin
      len = ($urandom_range(0, 49) == 0) ? int'($urandom_range(1, 1024))
                                         : int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) send_word(d, 8'($urandom), (i == len - 1), 1'b1);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      expq[d].delete();
      grp[d].delete();
    end
  endtask

  // Reference model + scoreboard. Accepted words are gathered per group;
  // a group closes after RATIO words or on din_last and is turned into the
  // expected packed word by placing word k in its lane.
  exp_t mon_e;
  int   mon_lane;
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (dout_vld_w[d] && dout_rdy[d]) begin
          chk($sformatf("out_expected%0d", d), 32'(expq[d].size() != 0), 32'd1);
          if (expq[d].size() != 0) begin
            mon_e = expq[d].pop_front();
            chk($sformatf("mdl_dout%0d", d), get_dout(d), mon_e.data);
            chk($sformatf("mdl_keep%0d", d), 32'(get_keep(d)), 32'(mon_e.keep));
            chk($sformatf("mdl_last%0d", d), 32'(dout_last_w[d]), 32'(mon_e.last));
          end
        end
        if (din_vld[d] && din_rdy_w[d]) begin
          grp[d].push_back(din[d]);
          if (grp[d].size() == ratio_of(d) || din_last[d]) begin
            mon_e.data = '0;
            mon_e.keep = '0;
            for (int k = 0; k < grp[d].size(); k++) begin
              mon_lane = msb_of(d) ? ratio_of(d) - 1 - k : k;
              mon_e.data = mon_e.data | (32'(grp[d][k]) << (mon_lane * 8));
              mon_e.keep[mon_lane] = 1'b1;
            end
            mon_e.last = din_last[d];
            expq[d].push_back(mon_e);
            grp[d].delete();
          end
        end
      end
    end
  end

  initial begin
    int budget;
    vectors     = 0;
    miscompares = 0;
    rand_rdy    = 1'b0;
    rst         = 1'b1;
    din_vld     = '0;
    din_last    = '0;
    dout_rdy    = 3'b111;
    for (int d = 0; d < 3; d++) din[d] = '0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_vld%0d", d), 32'(dout_vld_w[d]), 32'd0);
      chk($sformatf("rst_dout%0d", d), get_dout(d), 32'd0);
      chk($sformatf("rst_keep%0d", d), 32'(get_keep(d)), 32'd0);
      chk($sformatf("rst_last%0d", d), 32'(dout_last_w[d]), 32'd0);
      chk($sformatf("rst_rdy%0d", d), 32'(din_rdy_w[d]), 32'd1);
    end

    // Full MSB-first group with last on the final word
    send_word(0, 8'h11, 1'b0, 1'b0);
    send_word(0, 8'h22, 1'b0, 1'b0);
    send_word(0, 8'h33, 1'b0, 1'b0);
    chk("t1_not_early", 32'(dout_vld_w[0]), 32'd0);
    send_word(0, 8'h44, 1'b1, 1'b0);
    chk_out(0, "t1", 32'h11223344, 4'hF, 1'b1);
    @(posedge clk); #1;
    chk("t1_vld_drop", 32'(dout_vld_w[0]), 32'd0);

    // Partial groups in both lane orders
    send_word(0, 8'h55, 1'b0, 1'b0);
    send_word(0, 8'h66, 1'b1, 1'b0);
    chk_out(0, "t2m", 32'h55660000, 4'hC, 1'b1);
    send_word(1, 8'h55, 1'b0, 1'b0);
    send_word(1, 8'h66, 1'b1, 1'b0);
    chk_out(1, "t2l", 32'h00006655, 4'h3, 1'b1);

    // Full LSB-first group without last
    send_word(1, 8'hA1, 1'b0, 1'b0);
    send_word(1, 8'hB2, 1'b0, 1'b0);
    send_word(1, 8'hC3, 1'b0, 1'b0);
    send_word(1, 8'hD4, 1'b0, 1'b0);
    chk_out(1, "t3", 32'hD4C3B2A1, 4'hF, 1'b0);

    // Ratio 2: single-word packet, then a full group
    send_word(2, 8'h12, 1'b1, 1'b0);
    chk_out(2, "t3s", 32'h00001200, 4'h2, 1'b1);
    send_word(2, 8'h9A, 1'b0, 1'b0);
    send_word(2, 8'hBC, 1'b0, 1'b0);
    chk_out(2, "t3f", 32'h00009ABC, 4'h3, 1'b0);
    @(posedge clk); #1;

    // Back-pressure: output held for 10 cycles, then the next group follows
    dout_rdy[0] = 1'b0;
    send_word(0, 8'hAA, 1'b0, 1'b0);
    send_word(0, 8'hBB, 1'b0, 1'b0);
    send_word(0, 8'hCC, 1'b0, 1'b0);
    send_word(0, 8'hDD, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      chk_out(0, "t4_hold", 32'hAABBCCDD, 4'hF, 1'b0);
      chk("t4_din_rdy", 32'(din_rdy_w[0]), 32'd0);
      @(posedge clk); #1;
    end
    dout_rdy[0] = 1'b1;
    send_word(0, 8'hEE, 1'b0, 1'b0);
    send_word(0, 8'hFF, 1'b0, 1'b0);
    send_word(0, 8'h01, 1'b0, 1'b0);
    send_word(0, 8'h02, 1'b1, 1'b0);
    chk_out(0, "t4_next", 32'hEEFF0102, 4'hF, 1'b1);
    @(posedge clk); #1;

    // Reset with a pending output clears it without waiting for a clock edge
    dout_rdy[0] = 1'b0;
    send_word(0, 8'h10, 1'b0, 1'b0);
    send_word(0, 8'h20, 1'b0, 1'b0);
    send_word(0, 8'h30, 1'b0, 1'b0);
    send_word(0, 8'h40, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    chk("t5_async_vld", 32'(dout_vld_w[0]), 32'd0);
    chk("t5_async_dout", get_dout(0), 32'd0);
    chk("t5_async_keep", 32'(get_keep(0)), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dout_rdy[0] = 1'b1;

    // Reset mid-packet discards the partial group
    send_word(0, 8'h77, 1'b0, 1'b0);
    send_word(0, 8'h88, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    chk("t5_mid_vld", 32'(dout_vld_w[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_word(0, 8'h01, 1'b0, 1'b0);
    send_word(0, 8'h02, 1'b0, 1'b0);
    send_word(0, 8'h03, 1'b0, 1'b0);
    send_word(0, 8'h04, 1'b1, 1'b0);
    chk_out(0, "t5_after", 32'h01020304, 4'hF, 1'b1);
    @(posedge clk); #1;

    // Random traffic on all three instances concurrently
    rand_rdy = 1'b1;
    fork
      run_random(0, 200);
      run_random(1, 50);
      run_random(2, 200);
    join
    rand_rdy = 1'b0;
    dout_rdy = 3'b111;

    budget = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("drain_out%0d", d), 32'(expq[d].size()), 32'd0);
      chk($sformatf("drain_grp%0d", d), 32'(grp[d].size()), 32'd0);
      chk($sformatf("drain_vld%0d", d), 32'(dout_vld_w[d]), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
